// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen: queues 16-bit data words from host packets in a FIFO and replays them
// onto the GPIO pins at one word every divider clocks. Underrun is reported as a sticky flag.
// Optional feature macro: GPIO_PG_CONFIG_PKT_EN enables runtime config packets (header 2'b11)
// that set the replay divider and can clear the underrun flag.
module gpio_pattern_gen #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 16,
   parameter int unsigned Div   = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] packet_in_i,
   input  logic             packet_in_valid_i,
   output logic             packet_in_ready_o,
   output logic [15:0]      pin_vals_o,
   output logic             pin_update_o,
   output logic             underrun_o,
   output logic             drop_o
);

   localparam int unsigned    AddrW    = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [15:0]    DivInit  = 16'(Div);
   localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

   typedef enum logic {StIdle, StRun} state_e;

   logic [15:0]      mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]   count_q;
   state_e           state_q;
   logic [15:0]      cnt_q;
   logic [15:0]      pin_vals_q;
   logic             pin_update_q, underrun_q, drop_q;

   logic [1:0]  hdr;
   logic        accept, push, pop, cfg_acc, fifo_empty, underrun_clr;
   logic [15:0] div_cur;

   // Bits outside the interpreted fields are intentionally ignored.
   logic unused_pkt_bits;
   assign unused_pkt_bits = ^{packet_in_i[Width-1:28], packet_in_i[25:16]};

   assign hdr        = packet_in_i[27:26];
   assign fifo_empty = (count_q == '0);
   assign accept     = packet_in_valid_i && (count_q != DepthCnt);
   assign push       = accept && (hdr == 2'b10);

`ifdef GPIO_PG_CONFIG_PKT_EN
   logic [15:0] div_q;
   logic        clr_q;

   assign cfg_acc      = accept && (hdr == 2'b11);
   assign div_cur      = div_q;
   assign underrun_clr = clr_q;

   // Runtime divider and deferred underrun clear, written by config packets.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= DivInit;
         clr_q <= 1'b0;
      end else begin
         clr_q <= cfg_acc && packet_in_i[16];
         if (cfg_acc) begin
            div_q <= (packet_in_i[15:0] == 16'd0) ? 16'd1 : packet_in_i[15:0];
         end
      end
   end
`else
   assign cfg_acc      = 1'b0;
   assign div_cur      = DivInit;
   assign underrun_clr = 1'b0;
`endif

   // Pop decision: first word out of idle, or a tick that finds data waiting.
   always_comb begin
      pop = 1'b0;
      unique case (state_q)
         StIdle:  pop = !fifo_empty;
         StRun:   pop = (cnt_q == 16'd0) && !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   // FIFO storage; contents need no reset since the count gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= packet_in_i[15:0];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Replay FSM with registered pin, update, underrun and drop outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         pin_vals_q   <= '0;
         pin_update_q <= 1'b0;
         underrun_q   <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         pin_update_q <= pop;
         drop_q       <= accept && !push && !cfg_acc;
         if (underrun_clr) underrun_q <= 1'b0;
         if (pop) begin
            pin_vals_q <= mem_q[rd_ptr_q];
            cnt_q      <= div_cur - 16'd1;
         end
         unique case (state_q)
            StIdle: begin
               if (pop) state_q <= StRun;
            end
            StRun: begin
               if (cnt_q != 16'd0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else if (fifo_empty) begin
                  // Tick with nothing queued: hold pins, flag it, wait for new data.
                  underrun_q <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign packet_in_ready_o = (count_q != DepthCnt);
   assign pin_vals_o        = pin_vals_q;
   assign pin_update_o      = pin_update_q;
   assign underrun_o        = underrun_q;
   assign drop_o            = drop_q;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen: directed scenarios plus random traffic, all checked each cycle
// against a timeline model (word queue, absolute next-tick cycle, sticky flags).
module tb_gpio_pattern_gen;

   localparam int unsigned Width = 32;
   localparam int unsigned Depth = 16;
   localparam int unsigned Div   = 16;

`ifdef GPIO_PG_CONFIG_PKT_EN
   localparam bit CfgEn = 1'b1;
`else
   localparam bit CfgEn = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic [Width-1:0] packet_in_i = '0;
   logic             packet_in_valid_i = 1'b0;
   logic             packet_in_ready_o;
   logic [15:0]      pin_vals_o;
   logic             pin_update_o;
   logic             underrun_o;
   logic             drop_o;

   gpio_pattern_gen #(
      .Width (Width),
      .Depth (Depth),
      .Div   (Div)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .packet_in_i       (packet_in_i),
      .packet_in_valid_i (packet_in_valid_i),
      .packet_in_ready_o (packet_in_ready_o),
      .pin_vals_o        (pin_vals_o),
      .pin_update_o      (pin_update_o),
      .underrun_o        (underrun_o),
      .drop_o            (drop_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model state.
   logic [15:0] mq[$];
   bit          m_run;
   int          m_next_tick;
   int          m_cyc;
   int          m_div;
   logic [15:0] m_pin;
   bit          m_upd, m_under, m_drop, m_clr_pend;
   int          n_updates;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_run = 0; m_next_tick = 0; m_cyc = 0; m_div = Div;
      m_pin = '0; m_upd = 0; m_under = 0; m_drop = 0; m_clr_pend = 0;
   endtask

   // One clock: check outputs against the model, drive inputs, advance model across the edge.
   task automatic step(input bit v, input logic [31:0] pkt, output bit acc);
      bit popped;
      @(negedge clk_i);
      check_eq("pin_vals", 32'(pin_vals_o), 32'(m_pin));
      check_eq("pin_update", 32'(pin_update_o), 32'(m_upd));
      check_eq("underrun", 32'(underrun_o), 32'(m_under));
      check_eq("drop", 32'(drop_o), 32'(m_drop));
      check_eq("ready", 32'(packet_in_ready_o), 32'(mq.size() < Depth));
      if (pin_update_o) n_updates++;
      packet_in_valid_i = v;
      packet_in_i       = pkt;

      acc    = v && (mq.size() < Depth);
      popped = 0;
      if (m_clr_pend) m_under = 0;
      m_clr_pend = 0;
      if (!m_run) begin
         if (mq.size() > 0) begin
            m_pin = mq.pop_front(); popped = 1; m_run = 1; m_next_tick = m_cyc + m_div;
         end
      end else if (m_cyc == m_next_tick) begin
         if (mq.size() > 0) begin
            m_pin = mq.pop_front(); popped = 1; m_next_tick = m_cyc + m_div;
         end else begin
            m_under = 1; m_run = 0;
         end
      end
      m_upd  = popped;
      m_drop = 0;
      if (acc) begin
         if (pkt[27:26] == 2'b10) begin
            mq.push_back(pkt[15:0]);
         end else if (pkt[27:26] == 2'b11 && CfgEn) begin
            m_div      = (pkt[15:0] == 16'd0) ? 1 : int'(pkt[15:0]);
            m_clr_pend = pkt[16];
         end else begin
            m_drop = 1;
         end
      end
      m_cyc++;
      @(posedge clk_i);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, acc);
   endtask

   // Offer a packet until accepted, bounded.
   task automatic offer(input logic [31:0] pkt);
      bit acc;
      int tries;
      acc = 0;
      tries = 0;
      while (!acc && tries < 200) begin
         step(1'b1, pkt, acc);
         tries++;
      end
      check_eq("offer_accepted", 32'(acc), 32'd1);
   endtask

   task automatic async_reset();
      @(negedge clk_i);
      packet_in_valid_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      check_eq("rst_pin_vals", 32'(pin_vals_o), 32'h0);
      check_eq("rst_ready", 32'(packet_in_ready_o), 32'd1);
      check_eq("rst_underrun", 32'(underrun_o), 32'd0);
      check_eq("rst_update", 32'(pin_update_o), 32'd0);
      check_eq("rst_drop", 32'(drop_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      bit acc;
      int upd0;
      model_reset();
      n_updates = 0;
      #12;
      check_eq("init_pin_vals", 32'(pin_vals_o), 32'h0);
      check_eq("init_ready", 32'(packet_in_ready_o), 32'd1);
      check_eq("init_underrun", 32'(underrun_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Two back-to-back data words, then underrun and hold of the last value.
      step(1'b1, 32'h0800_1234, acc);
      step(1'b1, 32'h0800_ABCD, acc);
      idle(40);
      check_eq("hold_abcd", 32'(pin_vals_o), 32'h0000_ABCD);

      // Single word then silence.
      async_reset();
      offer(32'h0800_00FF);
      idle(25);
      check_eq("underrun_sticky", 32'(underrun_o), 32'd1);
      check_eq("hold_00ff", 32'(pin_vals_o), 32'h0000_00FF);

      // Restart after underrun, then a config packet mid-run.
      offer(32'h0800_1111);
      offer(32'h0800_2222);
      offer(32'h0800_3333);
      idle(5);
      offer(32'h0C01_0004);
      idle(60);

      // Invalid header.
      offer(32'h0400_5555);
      idle(3);

      // Overfill: ready must drop, every word replays in order.
      async_reset();
      for (int i = 0; i < 20; i++) offer(32'h0800_0000 | 32'(16'hA000 + i));
      idle(20 * Div + 20);

      // Reset mid-run with words queued; nothing may replay afterwards.
      for (int i = 0; i < 8; i++) offer(32'h0800_0000 | 32'(16'h5000 + i));
      idle(Div + 2);
      async_reset();
      upd0 = n_updates;
      idle(40);
      check_eq("no_update_after_rst", 32'(n_updates - upd0), 32'd0);

      // Random traffic in phases of varying load.
      for (int ph = 0; ph < 12; ph++) begin
         int load;
         load = $urandom_range(0, 10);
         for (int i = 0; i < 250; i++) begin
            logic [31:0] pkt;
            int r;
            r   = $urandom_range(0, 9);
            pkt = {4'h0, 2'b10, 10'h0, 16'($urandom)};
            if (r == 7) begin
               pkt = {4'h0, 2'b11, 9'h0, 1'($urandom), 16'($urandom_range(0, 6))};
            end else if (r == 8) begin
               pkt[27:26] = 2'b00;
            end else if (r == 9) begin
               pkt[27:26] = 2'b01;
            end
            step($urandom_range(0, 9) < load, pkt, acc);
         end
         if (ph == 6) async_reset();
      end
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit.
   initial begin
      #2_000_000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
